multi_cycle_ctrl: RTL

Multi-cycle control FSM for the CPU datapath. Sequences each instruction through IF/ID/EXE/MEM/WB and drives every datapath control: PC and IR write enables, ALU source and op selects, memory strobes, write-back source, PC source, and the 2-bit RegDst select of the 5-bit write-register 4:1 mux. Sits between the instruction register's opcode field and the datapath muxes/registers.

---
 rtl/multi_cycle_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM: walks each instruction through IF/ID/EXE/MEM/WB
// and drives the datapath enables and mux selects from the current state.
module multi_cycle_ctrl (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegDSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic [1:0] PCSrc
);

    typedef enum logic [2:0] {
        sIF    = 3'b000,
        sID    = 3'b001,
        sExeLs = 3'b010,
        sMem   = 3'b011,
        sWbLd  = 3'b100,
        sExeBr = 3'b101,
        sExeAl = 3'b110,
        sWbAl  = 3'b111
    } ctrlStateT;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    ctrlStateT stateQ, stateD;
    logic      haltedQ, haltedD;
    logic      isRType, isAlImm;
    logic      alSrcB, alExt;
    logic [2:0] alOp;

    assign isRType = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_SLT);
    assign isAlImm = (opcode == OP_ADDIU) || (opcode == OP_ORI);

    // Halt keeps the register at IF; the flag alone distinguishes it.
    assign state = stateQ;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stateQ  <= sIF;
            haltedQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            haltedQ <= haltedD;
        end
    end

    // ALU controls for the EXE_AL/WB_AL pair, held steady across both states.
    always_comb begin
        alSrcB = 1'b0;
        alExt  = 1'b0;
        alOp   = ALU_ADD;
        case (opcode)
            OP_SUB:   alOp = ALU_SUB;
            OP_AND:   alOp = ALU_AND;
            OP_SLT:   alOp = ALU_SLT;
            OP_ADDIU: begin alSrcB = 1'b1; alExt = 1'b1; alOp = ALU_ADD; end
            OP_ORI:   begin alSrcB = 1'b1; alExt = 1'b0; alOp = ALU_OR;  end
            default:  ;
        endcase
    end

    always_comb begin
        stateD    = stateQ;
        haltedD   = haltedQ;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        // Outputs are held at 0 while in reset or halted.
        if (Reset && !haltedQ) begin
            case (stateQ)
                sIF: begin
                    InsMemRW = 1'b1;
                    IRWre    = 1'b1;
                    stateD   = sID;
                end
                sID: begin
                    if (isRType || isAlImm) begin
                        stateD = sExeAl;
                    end else if (opcode == OP_LW || opcode == OP_SW) begin
                        stateD = sExeLs;
                    end else if (opcode == OP_BEQ) begin
                        stateD = sExeBr;
                    end else if (opcode == OP_HALT) begin
                        haltedD = 1'b1;
                        stateD  = sIF;
                    end else begin
                        PCWre  = 1'b1;
                        stateD = sIF;
                        if (opcode == OP_J) begin
                            PCSrc = 2'b11;
                        end else if (opcode == OP_JR) begin
                            PCSrc = 2'b10;
                        end else if (opcode == OP_JAL) begin
                            PCSrc     = 2'b11;
                            RegWre    = 1'b1;
                            RegDst    = 2'b00;
                            WrRegDSrc = 1'b0;
                        end
                    end
                end
                sExeAl: begin
                    ALUSrcB = alSrcB;
                    ALUOp   = alOp;
                    ExtSel  = alExt;
                    stateD  = sWbAl;
                end
                sWbAl: begin
                    ALUSrcB   = alSrcB;
                    ALUOp     = alOp;
                    ExtSel    = alExt;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = isRType ? 2'b10 : 2'b01;
                    PCWre     = 1'b1;
                    stateD    = sIF;
                end
                sExeBr: begin
                    ALUOp  = ALU_SUB;
                    ExtSel = 1'b1;
                    PCWre  = 1'b1;
                    PCSrc  = zero ? 2'b01 : 2'b00;
                    stateD = sIF;
                end
                sExeLs: begin
                    ALUSrcB = 1'b1;
                    ALUOp   = ALU_ADD;
                    ExtSel  = 1'b1;
                    stateD  = sMem;
                end
                sMem: begin
                    ALUSrcB = 1'b1;
                    ALUOp   = ALU_ADD;
                    ExtSel  = 1'b1;
                    if (opcode == OP_LW) begin
                        mRD    = 1'b1;
                        stateD = sWbLd;
                    end else begin
                        mWR    = 1'b1;
                        PCWre  = 1'b1;
                        stateD = sIF;
                    end
                end
                sWbLd: begin
                    RegWre    = 1'b1;
                    RegDst    = 2'b01;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b1;
                    PCWre     = 1'b1;
                    stateD    = sIF;
                end
                default: stateD = sIF;
            endcase
        end
    end

endmodule
